// File: rtl/wb_interconnect_arb_nxm.sv
// N-by-M Wishbone crossbar with per-slave round-robin arbitration,
// an internal error slave for unmapped addresses and a per-connection ACK timeout.
module wb_interconnect_arb_nxm #(
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int N_MASTERS      = 2,
    parameter int N_SLAVES       = 4,
    parameter logic [2*N_SLAVES*WB_ADDR_WIDTH-1:0] ADDR_RANGES = '0,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0]    m_adr,
    input  logic [N_MASTERS*WB_DATA_WIDTH-1:0]    m_dat_w,
    input  logic [N_MASTERS*3-1:0]                m_cti,
    input  logic [N_MASTERS*2-1:0]                m_bte,
    input  logic [N_MASTERS*WB_DATA_WIDTH/8-1:0]  m_sel,
    input  logic [N_MASTERS-1:0]                  m_cyc,
    input  logic [N_MASTERS-1:0]                  m_stb,
    input  logic [N_MASTERS-1:0]                  m_we,
    output logic [N_MASTERS*WB_DATA_WIDTH-1:0]    m_dat_r,
    output logic [N_MASTERS-1:0]                  m_ack,
    output logic [N_MASTERS-1:0]                  m_err,
    output logic [N_SLAVES*WB_ADDR_WIDTH-1:0]     s_adr,
    output logic [N_SLAVES*WB_DATA_WIDTH-1:0]     s_dat_w,
    output logic [N_SLAVES*3-1:0]                 s_cti,
    output logic [N_SLAVES*2-1:0]                 s_bte,
    output logic [N_SLAVES*WB_DATA_WIDTH/8-1:0]   s_sel,
    output logic [N_SLAVES-1:0]                   s_cyc,
    output logic [N_SLAVES-1:0]                   s_stb,
    output logic [N_SLAVES-1:0]                   s_we,
    input  logic [N_SLAVES*WB_DATA_WIDTH-1:0]     s_dat_r,
    input  logic [N_SLAVES-1:0]                   s_ack,
    input  logic [N_SLAVES-1:0]                   s_err
);

    localparam int AW  = WB_ADDR_WIDTH;
    localparam int DW  = WB_DATA_WIDTH;
    localparam int SLW = DW / 8;
    localparam int SW  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int MW  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int CW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [N_MASTERS-1:0] gnt_vld;
    logic [SW-1:0]        gnt_sel [N_MASTERS];
    logic [CW-1:0]        cnt     [N_MASTERS];
    logic [N_MASTERS-1:0] err_slv;
    logic [N_MASTERS-1:0] to_err;
    logic [MW-1:0]        ptr     [N_SLAVES];

    logic [N_MASTERS-1:0] dec_hit;
    logic [SW-1:0]        dec_idx [N_MASTERS];
    logic [N_MASTERS-1:0] on_tgt;
    logic [N_MASTERS-1:0] fwd_stb;
    logic [N_MASTERS-1:0] stall;
    logic [N_MASTERS-1:0] tmo;
    logic [N_MASTERS-1:0] rel;
    logic [N_MASTERS-1:0] req;
    logic [N_SLAVES-1:0]  owned;
    logic [N_SLAVES-1:0]  win_vld;
    logic [MW-1:0]        win     [N_SLAVES];

    // Descending scan so the lowest-index overlapping range wins.
    always_comb begin
        for (int k = 0; k < N_MASTERS; k++) begin
            dec_hit[k] = 1'b0;
            dec_idx[k] = '0;
            for (int i = N_SLAVES - 1; i >= 0; i--) begin
                if (m_adr[k*AW +: AW] >= ADDR_RANGES[(2*(N_SLAVES-i)-1)*AW +: AW] &&
                    m_adr[k*AW +: AW] <= ADDR_RANGES[(2*(N_SLAVES-i)-2)*AW +: AW]) begin
                    dec_hit[k] = 1'b1;
                    dec_idx[k] = SW'(i);
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N_MASTERS; k++) begin
            on_tgt[k]  = dec_hit[k] && (dec_idx[k] == gnt_sel[k]);
            fwd_stb[k] = gnt_vld[k] & m_cyc[k] & m_stb[k] & on_tgt[k];
            stall[k]   = fwd_stb[k] & ~s_ack[gnt_sel[k]] & ~s_err[gnt_sel[k]];
            tmo[k]     = (TIMEOUT_CYCLES != 0) && stall[k] && (cnt[k] == TO_LAST);
            rel[k]     = gnt_vld[k] &
                         (~m_cyc[k] | (m_stb[k] & ~on_tgt[k]) | tmo[k]);
            req[k]     = m_cyc[k] & m_stb[k] & dec_hit[k] & ~gnt_vld[k];
        end
    end

    // A slave stays owned through its release cycle, which gives the idle gap.
    always_comb begin
        int idx;
        idx = 0;
        for (int i = 0; i < N_SLAVES; i++) begin
            owned[i]   = 1'b0;
            win_vld[i] = 1'b0;
            win[i]     = '0;
            for (int k = 0; k < N_MASTERS; k++) begin
                if (gnt_vld[k] && gnt_sel[k] == SW'(i))
                    owned[i] = 1'b1;
            end
            if (!owned[i]) begin
                for (int j = 0; j < N_MASTERS; j++) begin
                    idx = (int'(ptr[i]) + j) % N_MASTERS;
                    if (!win_vld[i] && req[idx] && dec_idx[idx] == SW'(i)) begin
                        win_vld[i] = 1'b1;
                        win[i]     = MW'(idx);
                    end
                end
            end
        end
    end

    always_comb begin
        s_adr   = '0;
        s_dat_w = '0;
        s_cti   = '0;
        s_bte   = '0;
        s_sel   = '0;
        s_cyc   = '0;
        s_stb   = '0;
        s_we    = '0;
        m_dat_r = '0;
        m_ack   = '0;
        m_err   = err_slv | to_err;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (gnt_vld[k]) begin
                s_adr[int'(gnt_sel[k])*AW +: AW]    = m_adr[k*AW +: AW];
                s_dat_w[int'(gnt_sel[k])*DW +: DW]  = m_dat_w[k*DW +: DW];
                s_cti[int'(gnt_sel[k])*3 +: 3]      = m_cti[k*3 +: 3];
                s_bte[int'(gnt_sel[k])*2 +: 2]      = m_bte[k*2 +: 2];
                s_sel[int'(gnt_sel[k])*SLW +: SLW]  = m_sel[k*SLW +: SLW];
                s_cyc[gnt_sel[k]]                   = m_cyc[k];
                s_stb[gnt_sel[k]]                   = fwd_stb[k];
                s_we[gnt_sel[k]]                    = m_we[k];
                m_dat_r[k*DW +: DW] = s_dat_r[int'(gnt_sel[k])*DW +: DW];
                m_ack[k]            = s_ack[gnt_sel[k]];
                m_err[k]            = m_err[k] | s_err[gnt_sel[k]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_vld <= '0;
            err_slv <= '0;
            to_err  <= '0;
            for (int k = 0; k < N_MASTERS; k++) begin
                gnt_sel[k] <= '0;
                cnt[k]     <= '0;
            end
            for (int i = 0; i < N_SLAVES; i++)
                ptr[i] <= '0;
        end else begin
            for (int k = 0; k < N_MASTERS; k++) begin
                err_slv[k] <= m_cyc[k] & m_stb[k] & ~dec_hit[k] &
                              ~gnt_vld[k] & ~err_slv[k];
                to_err[k]  <= tmo[k];
                if (rel[k]) begin
                    gnt_vld[k] <= 1'b0;
                    cnt[k]     <= '0;
                end else if (stall[k]) begin
                    cnt[k] <= cnt[k] + CW'(1);
                end else if (fwd_stb[k]) begin
                    cnt[k] <= '0;
                end
            end
            for (int i = 0; i < N_SLAVES; i++) begin
                if (win_vld[i]) begin
                    gnt_vld[win[i]] <= 1'b1;
                    gnt_sel[win[i]] <= SW'(i);
                    cnt[win[i]]     <= '0;
                    ptr[i] <= (win[i] == MW'(N_MASTERS - 1)) ? '0 : win[i] + MW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_interconnect_arb_nxm.sv
// Directed self-checking bench for wb_interconnect_arb_nxm:
// decode, round-robin, unmapped error, timeout, lock/retarget, reset.
module tb_wb_interconnect_arb_nxm;

    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  m_adr;
    logic [63:0]  m_dat_w;
    logic [5:0]   m_cti;
    logic [3:0]   m_bte;
    logic [7:0]   m_sel;
    logic [1:0]   m_cyc;
    logic [1:0]   m_stb;
    logic [1:0]   m_we;
    logic [63:0]  m_dat_r;
    logic [1:0]   m_ack;
    logic [1:0]   m_err;
    logic [127:0] s_adr;
    logic [127:0] s_dat_w;
    logic [11:0]  s_cti;
    logic [7:0]   s_bte;
    logic [15:0]  s_sel;
    logic [3:0]   s_cyc;
    logic [3:0]   s_stb;
    logic [3:0]   s_we;
    logic [127:0] s_dat_r;
    logic [3:0]   s_ack;
    logic [3:0]   s_err;
    logic [3:0]   ack_en;

    int n_chk = 0;
    int n_err = 0;

    wb_interconnect_arb_nxm #(
        .WB_ADDR_WIDTH (32),
        .WB_DATA_WIDTH (32),
        .N_MASTERS     (2),
        .N_SLAVES      (4),
        .ADDR_RANGES   ({32'h0000_0000, 32'h0000_0FFF,
                         32'h0000_1000, 32'h0000_1FFF,
                         32'h0000_2000, 32'h0000_2FFF,
                         32'h0000_3000, 32'h0000_3FFF}),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_adr   (m_adr),
        .m_dat_w (m_dat_w),
        .m_cti   (m_cti),
        .m_bte   (m_bte),
        .m_sel   (m_sel),
        .m_cyc   (m_cyc),
        .m_stb   (m_stb),
        .m_we    (m_we),
        .m_dat_r (m_dat_r),
        .m_ack   (m_ack),
        .m_err   (m_err),
        .s_adr   (s_adr),
        .s_dat_w (s_dat_w),
        .s_cti   (s_cti),
        .s_bte   (s_bte),
        .s_sel   (s_sel),
        .s_cyc   (s_cyc),
        .s_stb   (s_stb),
        .s_we    (s_we),
        .s_dat_r (s_dat_r),
        .s_ack   (s_ack),
        .s_err   (s_err)
    );

    always #5 clk = ~clk;

    assign s_dat_r = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
    assign s_err   = 4'b0000;

    // Classic registered slaves: one wait state, ack every other cycle.
    always_ff @(posedge clk) begin
        if (rst) s_ack <= '0;
        else s_ack <= s_cyc & s_stb & ~s_ack & ack_en;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input int k, input logic c, input logic s,
                         input logic w, input logic [31:0] a,
                         input logic [31:0] d);
        m_cyc[k] = c;
        m_stb[k] = s;
        m_we[k]  = w;
        m_adr[k*32 +: 32]   = a;
        m_dat_w[k*32 +: 32] = d;
        m_sel[k*4 +: 4]     = 4'hF;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int order [$];
        int done [2];
        int stall;
        int acks;
        bit seen;
        bit first;
        bit blk;

        rst    = 1'b1;
        m_adr  = '0;
        m_dat_w = '0;
        m_cti  = '0;
        m_bte  = '0;
        m_sel  = '0;
        m_cyc  = '0;
        m_stb  = '0;
        m_we   = '0;
        ack_en = 4'b1011;
        repeat (3) tick();
        check("rst_m_ack", m_ack, 2'b00);
        check("rst_m_err", m_err, 2'b00);
        check("rst_s_cyc", s_cyc, 4'h0);
        check("rst_s_stb", s_stb, 4'h0);
        rst = 1'b0;
        tick();

        // Decode and pass-through
        drive(0, 1, 1, 1, 32'h0000_1004, 32'hDEAD_BEEF);
        check("pt_no_early_cyc", s_cyc, 4'h0);
        tick();
        check("pt_s_cyc", s_cyc, 4'b0010);
        check("pt_s_stb", s_stb, 4'b0010);
        check("pt_s1_adr", s_adr[63:32], 32'h0000_1004);
        check("pt_s1_dat", s_dat_w[63:32], 32'hDEAD_BEEF);
        check("pt_s1_sel", s_sel[7:4], 4'hF);
        check("pt_s1_we", s_we[1], 1'b1);
        check("pt_no_ack_yet", m_ack, 2'b00);
        tick();
        check("pt_s1_ack", s_ack[1], 1'b1);
        check("pt_m_ack", m_ack, 2'b01);
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        check("pt_release", s_cyc, 4'h0);

        // Round-robin on s0
        drive(0, 1, 1, 0, 32'h0000_0010, 32'h0);
        drive(1, 1, 1, 0, 32'h0000_0020, 32'h0);
        done[0] = 0;
        done[1] = 0;
        first = 1'b1;
        for (int n = 0; n < 80 && order.size() < 8; n++) begin
            tick();
            check("rr_one_ack", m_ack == 2'b11, 1'b0);
            for (int k = 0; k < 2; k++) begin
                if (m_ack[k]) begin
                    if (first) begin
                        check("rr_dat_m0", m_dat_r[31:0], 32'hC0DE_0000);
                        check("rr_dat_m1_zero", m_dat_r[63:32], 32'h0);
                        first = 1'b0;
                    end
                    order.push_back(k);
                    done[k]++;
                    drive(k, 0, 0, 0, 32'h0, 32'h0);
                end else if (!m_cyc[k] && done[k] < 4) begin
                    drive(k, 1, 1, 0, (k == 0) ? 32'h10 : 32'h20, 32'h0);
                end
            end
        end
        check("rr_count", order.size(), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("rr_order%0d", i),
                  (i < order.size()) ? order[i] : 99, i % 2);
        tick();

        // Unmapped read
        drive(1, 1, 1, 0, 32'hFFFF_0000, 32'h0);
        check("um_no_early_err", m_err, 2'b00);
        tick();
        check("um_err", m_err, 2'b10);
        check("um_no_cyc", s_cyc, 4'h0);
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        tick();
        check("um_err_one_cycle", m_err, 2'b00);
        check("um_no_cyc2", s_cyc, 4'h0);

        // Timeout on s2
        drive(0, 1, 1, 0, 32'h0000_2000, 32'h0);
        stall = 0;
        seen  = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            if (m_err[0]) seen = 1'b1;
            else if (s_stb[2]) stall++;
        end
        check("to_err_seen", seen, 1'b1);
        check("to_stall_cycles", stall, 8);
        check("to_s2_dropped", s_cyc[2], 1'b0);
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        drive(1, 1, 1, 0, 32'h0000_2010, 32'h0);
        tick();
        check("to_err_single", m_err, 2'b00);
        check("to_m1_granted", s_stb[2], 1'b1);
        check("to_m1_adr", s_adr[95:64], 32'h0000_2010);
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        tick();

        // Bus lock across three beats, then retarget to s3
        drive(0, 1, 1, 0, 32'h0000_0100, 32'h0);
        drive(1, 1, 1, 0, 32'h0000_0200, 32'h0);
        acks = 0;
        blk  = 1'b1;
        for (int n = 0; n < 30 && acks < 3; n++) begin
            tick();
            if (m_ack[1] || (s_stb[0] && s_adr[31:0] == 32'h200)) blk = 1'b0;
            if (m_ack[0]) begin
                acks++;
                if (acks < 3) drive(0, 1, 1, 0, 32'h100 + 32'(acks * 4), 32'h0);
            end
        end
        check("lk_beats", acks, 3);
        check("lk_m1_blocked", blk, 1'b1);
        drive(0, 1, 1, 0, 32'h0000_3000, 32'h0);
        tick();
        check("rt_idle_gap", s_cyc, 4'h0);
        tick();
        check("rt_s3_stb", s_stb[3], 1'b1);
        check("rt_s3_adr", s_adr[127:96], 32'h0000_3000);
        check("rt_m1_s0", s_stb[0], 1'b1);
        check("rt_m1_adr", s_adr[31:0], 32'h0000_0200);
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        repeat (2) tick();

        // Reset in the middle of an m0 -> s1 burst
        drive(0, 1, 1, 1, 32'h0000_1000, 32'h1234_5678);
        tick();
        check("rb_granted", s_stb[1], 1'b1);
        tick();
        rst = 1'b1;
        drive(1, 1, 1, 0, 32'h0000_1100, 32'h0);
        tick();
        check("rb_s_cyc", s_cyc, 4'h0);
        check("rb_s_stb", s_stb, 4'h0);
        check("rb_m_ack", m_ack, 2'b00);
        check("rb_m_err", m_err, 2'b00);
        check("rb_dat_r", m_dat_r, 64'h0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        check("rb_m1_first", s_stb[1], 1'b1);
        check("rb_m1_adr", s_adr[63:32], 32'h0000_1100);
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/wb_interconnect_arb_nxm.md
# wb_interconnect_arb_nxm

Parametrised Wishbone crossbar that connects N_MASTERS bus masters to N_SLAVES address-mapped slaves with per-slave round-robin arbitration. It adds three behaviours to the fixed-size pass-through interconnects: an internal error responder for unmapped addresses, a per-connection ACK timeout, and on-the-fly retargeting inside a held CYC. It sits between the CPU/DMA masters and the peripheral/memory slaves in the system fabric.

## Interface
- WB_ADDR_WIDTH, 32, address width
- WB_DATA_WIDTH, 32, data width; must be a multiple of 8, giving SEL width WB_DATA_WIDTH/8
- N_MASTERS, 2, master count, 1..16
- N_SLAVES, 4, slave count, 1..16
- ADDR_RANGES, 0, packed {S0_BASE, S0_LIMIT, S1_BASE, S1_LIMIT, ...}, 2*N_SLAVES*WB_ADDR_WIDTH bits
  - Slave i base is at [(2*(N_SLAVES-i)-1)*AW +: AW] and its limit at [(2*(N_SLAVES-i)-2)*AW +: AW].
  - The limit is inclusive.
- TIMEOUT_CYCLES, 256, stall cycles before the interconnect aborts a transfer; 0 disables the timeout
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- m_adr/m_dat_w  in  N_MASTERS*AW / N_MASTERS*DW  master address and write data; master k uses slice k
- m_cti/m_bte  in  N_MASTERS*3 / N_MASTERS*2  burst tags
- m_sel  in  N_MASTERS*DW/8  byte selects
- m_cyc/m_stb/m_we  in  N_MASTERS  cycle, strobe, write enable
- m_dat_r  out  N_MASTERS*DW  read data
- m_ack/m_err  out  N_MASTERS  acknowledge, error
- s_adr/s_dat_w/s_cti/s_bte/s_sel  out  same per-slave widths as the master side  forwarded request
- s_cyc/s_stb/s_we  out  N_SLAVES  forwarded control
- s_dat_r  in  N_SLAVES*DW  slave read data
- s_ack/s_err  in  N_SLAVES  slave acknowledge, error

## Operation
- Address decode
  - Slave i is hit when base_i <= adr <= limit_i.
  - If ranges overlap, the lowest-index hit wins.
  - An address with no hit goes to the internal error slave.
- Arbitration
  - Each slave has a round-robin arbiter with a priority pointer.
  - A request is m_cyc[k] & m_stb[k] decoding to that slave.
  - The grant goes to the first requester at or after the pointer, wrapping.
  - On grant, the pointer moves to winner+1 mod N_MASTERS.
  - A master holds at most one grant at a time.
- Connection
  - While granted, the master's request fields go to the slave.
  - The slave's dat_r, ack and err return to that master only.
  - Non-granted slaves drive s_cyc=s_stb=0; other outputs are don't-care but held at 0.
  - Non-granted masters see ack=err=0 and dat_r=0.
- Release
  - The grant is released when m_cyc drops.
  - It is also released when the master presents m_stb to an address decoding to a different slave (or unmapped); the master then re-arbitrates for the new target.
  - It is also released on timeout.
  - m_stb low with m_cyc high keeps the grant (bus lock across beats).
- Error slave (one per master)
  - m_cyc&m_stb to an unmapped address gives m_err=1 for exactly one cycle, starting the cycle after the request is seen.
  - It asserts again for each further strobed beat.
- Timeout
  - A per-connection counter increments every cycle s_stb=1 while s_ack=0 and s_err=0.
  - The counter clears on ack/err or a new grant.
  - When it reaches TIMEOUT_CYCLES, the following happens in the next cycle:
    - m_err is pulsed for 1 cycle.
    - s_cyc and s_stb drop.
    - The grant is released.
  - A slave ack arriving in that same cycle is dropped.
- Reset
  - All grants clear and all pointers go to 0.
  - All m_ack, m_err, s_cyc and s_stb are 0.
  - All data outputs are 0.
  - An in-flight transfer is abandoned with no ack or err generated.

## Timing
- Grant latency: a request seen at edge t is registered as a grant, and s_cyc/s_stb rise in cycle t+1.
- While granted, the request and response paths are combinational (no added latency per beat). A slave single-cycle ack gives 1 wait state only on the first beat.
- Retarget costs 1 idle cycle: the old grant clears, then the new grant is issued.
- Simultaneous requests to one slave: exactly one grant per cycle; losers see no ack/err and wait.
- Grant release and a new request in the same cycle: the new grant is issued at the following edge.
- Error slave response latency: 1 cycle.
- Timeout abort: m_err is asserted in the cycle after the counter reaches TIMEOUT_CYCLES.

## Test plan
- Decode and pass-through:
  - Setup: N_MASTERS=2, N_SLAVES=4, ranges 0x0000-0x0FFF / 0x1000-0x1FFF / ... .
  - Stimulus: m0 writes 0xDEADBEEF to 0x1004.
  - Response: s1 sees adr 0x1004, dat 0xDEADBEEF, sel 0xF one cycle later; s1 acks and m0 sees ack in the same cycle.
- Round-robin:
  - Stimulus: m0 and m1 both hold requests to s0 for 4 single-beat cycles each, dropping cyc after ack.
  - Response: grants alternate m0, m1, m0, m1.
- Unmapped:
  - Stimulus: m1 reads 0xFFFF0000.
  - Response: m1_err=1 for one cycle, one cycle after the request; all s_cyc stay 0.
- Timeout:
  - Setup: TIMEOUT_CYCLES=8; s2 never acks.
  - Stimulus: m0 accesses s2.
  - Response: after 8 stalled cycles, m0_err pulses once and s2_cyc drops; a subsequent m1 request to s2 is granted.
- Lock and retarget:
  - Stimulus: m0 holds cyc across 3 beats to s0, then strobes s3 without dropping cyc.
  - Response: m1 requesting s0 is blocked until the retarget; s3 is granted with a 1 idle cycle gap.
- Reset mid-burst:
  - Stimulus: assert rst during an m0→s1 burst.
  - Response: the next cycle has all s_cyc/s_stb and m_ack/m_err at 0; after rst deasserts, m1 (requesting) is granted first because the pointer is 0 and m0 is idle.
